// File: rtl/load_store_unit_pkg.sv
// Shared memory defines for the load/store unit: funct3 codes, FSM states,
// data-bus structs and small helpers for access legality and store formatting.
package load_store_unit_pkg;

  localparam int LSU_XLEN           = 32;
  localparam int LSU_TIMEOUT_CYCLES = 16;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } lsu_funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } lsu_state_e;

  typedef struct packed {
    logic                req;
    logic [LSU_XLEN-1:0] addr;
    logic [LSU_XLEN-1:0] w_data;
    logic [3:0]          sel_byte;
    logic                w_en;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [LSU_XLEN-1:0] r_data;
    logic                ack;
  } type_peri2dbus_s;

  function automatic logic lsu_is_legal(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_W:        return addr_lo == 2'b00;
      F3_H, F3_HU: return ~addr_lo[0];
      F3_B, F3_BU: return 1'b1;
      default:     return 1'b0;
    endcase
  endfunction

  // Bit 2 of funct3 only carries signedness, so the low two bits pick the width.
  function automatic logic [3:0] lsu_sel_byte(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   return 4'b0001 << addr_lo;
      2'b01:   return addr_lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [LSU_XLEN-1:0] lsu_format_wdata(input logic [2:0] funct3,
                                                            input logic [LSU_XLEN-1:0] wdata);
    case (funct3[1:0])
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Combinational load extraction: picks the addressed byte/half from the bus
// word and sign- or zero-extends it according to funct3.
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [LSU_XLEN-1:0] r_data_i,
  input  logic [1:0]          addr_lo_i,
  input  logic [2:0]          funct3_i,
  output logic [LSU_XLEN-1:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = r_data_i[8*addr_lo_i +: 8];
    half_sel = addr_lo_i[1] ? r_data_i[31:16] : r_data_i[15:0];
    case (funct3_i)
      F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata_o = {24'd0, byte_sel};
      F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata_o = {16'd0, half_sel};
      default: rdata_o = r_data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one execute-stage memory request into a single
// data-bus transaction with alignment checking, load extension and a timeout.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN           = LSU_XLEN,
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [2:0]      lsu_funct3_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output type_dbus2peri_s lsu2dbus_o,
  input  type_peri2dbus_s dbus2lsu_i,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            lsu_done_o,
  output logic            lsu_stall_o,
  output logic            lsu_misalign_o,
  output logic            lsu_timeout_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  lsu_state_e      state_q, state_d;
  logic            req_q, req_d, w_en_q, w_en_d, we_q, we_d;
  logic            misalign_q, misalign_d, timeout_q, timeout_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [3:0]      sel_q, sel_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] load_data;

  lsu_load_align u_load_align (
    .r_data_i  (dbus2lsu_i.r_data),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (funct3_q),
    .rdata_o   (load_data)
  );

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // signal unassigned; skipping this default is what infers latches.
    state_d    = state_q;
    req_d      = req_q;
    w_en_d     = w_en_q;
    we_d       = we_q;
    misalign_d = misalign_q;
    timeout_d  = timeout_q;
    funct3_d   = funct3_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (lsu_req_i) begin
          misalign_d = 1'b0;
          timeout_d  = 1'b0;
          if (lsu_is_legal(lsu_funct3_i, lsu_addr_i[1:0])) begin
            state_d  = ST_BUSY;
            req_d    = 1'b1;
            w_en_d   = lsu_we_i;
            we_d     = lsu_we_i;
            funct3_d = lsu_funct3_i;
            addr_d   = lsu_addr_i;
            wdata_d  = lsu_format_wdata(lsu_funct3_i, lsu_wdata_i);
            sel_d    = lsu_we_i ? lsu_sel_byte(lsu_funct3_i, lsu_addr_i[1:0]) : 4'b1111;
            cnt_d    = '0;
          end else begin
            state_d    = ST_DONE;
            misalign_d = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        // Ack is tested first so it wins over a timeout in the same cycle.
        if (dbus2lsu_i.ack) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          w_en_d  = 1'b0;
          if (!we_q) rdata_d = load_data;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ST_DONE;
          req_d     = 1'b0;
          w_en_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      w_en_q     <= 1'b0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
      funct3_q   <= '0;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      w_en_q     <= w_en_d;
      we_q       <= we_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
      funct3_q   <= funct3_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
    end
  end

  assign lsu2dbus_o.req      = req_q;
  assign lsu2dbus_o.addr     = addr_q;
  assign lsu2dbus_o.w_data   = wdata_q;
  assign lsu2dbus_o.sel_byte = sel_q;
  assign lsu2dbus_o.w_en     = w_en_q;

  assign lsu_rdata_o    = rdata_q;
  assign lsu_done_o     = (state_q == ST_DONE);
  assign lsu_stall_o    = lsu_req_i & ~lsu_done_o;
  assign lsu_misalign_o = misalign_q;
  assign lsu_timeout_o  = timeout_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, extended loads, misalignment,
// timeout boundary, ack-in-idle and asynchronous reset during a bus access.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            lsu_req, lsu_we;
  logic [2:0]      lsu_funct3;
  logic [31:0]     lsu_addr, lsu_wdata;
  type_dbus2peri_s bus;
  type_peri2dbus_s resp;
  logic [31:0]     lsu_rdata;
  logic            lsu_done, lsu_stall, lsu_misalign, lsu_timeout;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int cycles;
  int dones;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lsu_req_i      (lsu_req),
    .lsu_we_i       (lsu_we),
    .lsu_funct3_i   (lsu_funct3),
    .lsu_addr_i     (lsu_addr),
    .lsu_wdata_i    (lsu_wdata),
    .lsu2dbus_o     (bus),
    .dbus2lsu_i     (resp),
    .lsu_rdata_o    (lsu_rdata),
    .lsu_done_o     (lsu_done),
    .lsu_stall_o    (lsu_stall),
    .lsu_misalign_o (lsu_misalign),
    .lsu_timeout_o  (lsu_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    lsu_req    = 1'b1;
    lsu_we     = we;
    lsu_funct3 = f3;
    lsu_addr   = addr;
    lsu_wdata  = wdata;
  endtask

  task automatic ack_now(input logic [31:0] rdata);
    resp.ack    = 1'b1;
    resp.r_data = rdata;
    tick();
    resp.ack    = 1'b0;
    resp.r_data = 32'h0;
  endtask

  task automatic release_req();
    lsu_req = 1'b0;
    tick();
  endtask

  initial begin
    lsu_req = 0; lsu_we = 0; lsu_funct3 = 0; lsu_addr = 0; lsu_wdata = 0;
    resp = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'd0, bus.req}, 32'd0);
    check("rst_sel", {28'd0, bus.sel_byte}, 32'd0);
    check("rst_addr", bus.addr, 32'd0);
    check("rst_wdata", bus.w_data, 32'd0);
    check("rst_rdata", lsu_rdata, 32'd0);
    check("rst_flags", {28'd0, lsu_done, lsu_misalign, lsu_timeout, bus.w_en}, 32'd0);
    rst_n = 1'b1;
    tick();

    // SW 0xDEADBEEF to 0x100, memory acks in the second bus cycle
    drive(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    #1 check("sw_stall", {31'd0, lsu_stall}, 32'd1);
    tick();
    check("sw_req", {31'd0, bus.req}, 32'd1);
    check("sw_sel", {28'd0, bus.sel_byte}, 32'hF);
    check("sw_wdata", bus.w_data, 32'hDEADBEEF);
    check("sw_wen", {31'd0, bus.w_en}, 32'd1);
    check("sw_addr", bus.addr, 32'h100);
    tick();
    check("sw_req2", {31'd0, bus.req}, 32'd1);
    ack_now(32'h0);
    check("sw_done", {31'd0, lsu_done}, 32'd1);
    check("sw_req_drop", {31'd0, bus.req}, 32'd0);
    check("sw_stall_done", {31'd0, lsu_stall}, 32'd0);
    check("sw_flags", {30'd0, lsu_misalign, lsu_timeout}, 32'd0);
    release_req();
    check("sw_done_1cyc", {31'd0, lsu_done}, 32'd0);

    // SB 0xA5 to 0x103
    drive(1'b1, 3'b000, 32'h103, 32'h000000A5);
    tick();
    check("sb_sel", {28'd0, bus.sel_byte}, 32'h8);
    check("sb_wdata", bus.w_data, 32'hA5A5A5A5);
    ack_now(32'h0);
    check("sb_done", {31'd0, lsu_done}, 32'd1);
    release_req();

    // LB / LBU from 0x103
    drive(1'b0, 3'b000, 32'h103, 32'h0);
    tick();
    check("lb_sel", {28'd0, bus.sel_byte}, 32'hF);
    check("lb_wen", {31'd0, bus.w_en}, 32'd0);
    ack_now(32'hA5000000);
    check("lb_rdata", lsu_rdata, 32'hFFFFFFA5);
    release_req();
    check("lb_rdata_hold", lsu_rdata, 32'hFFFFFFA5);
    drive(1'b0, 3'b100, 32'h103, 32'h0);
    tick();
    ack_now(32'hA5000000);
    check("lbu_rdata", lsu_rdata, 32'h000000A5);
    release_req();

    // LH / LHU from 0x102
    drive(1'b0, 3'b001, 32'h102, 32'h0);
    tick();
    ack_now(32'h80017FFF);
    check("lh_rdata", lsu_rdata, 32'hFFFF8001);
    release_req();
    drive(1'b0, 3'b101, 32'h102, 32'h0);
    tick();
    ack_now(32'h80017FFF);
    check("lhu_rdata", lsu_rdata, 32'h00008001);
    release_req();

    // Ack while idle is ignored
    ack_now(32'h12345678);
    check("idle_ack_done", {31'd0, lsu_done}, 32'd0);
    check("idle_ack_rdata", lsu_rdata, 32'h00008001);

    // Misaligned LW and illegal funct3
    drive(1'b0, 3'b010, 32'h101, 32'h0);
    tick();
    check("mis_lw", {29'd0, bus.req, lsu_done, lsu_misalign}, 32'b011);
    release_req();
    check("mis_lw_hold", {30'd0, lsu_done, lsu_misalign}, 32'b01);
    drive(1'b0, 3'b011, 32'h100, 32'h0);
    tick();
    check("mis_f3", {29'd0, bus.req, lsu_done, lsu_misalign}, 32'b011);
    tick();  // request held through DONE: this cycle must be IDLE
    check("done_no_accept", {30'd0, bus.req, lsu_done}, 32'b00);
    tick();
    check("idle_accept", {30'd0, lsu_done, lsu_misalign}, 32'b11);
    release_req();

    // Load with no ack: timeout after 16 bus-request cycles
    drive(1'b0, 3'b010, 32'h100, 32'h0);
    tick();
    cycles = 0;
    for (int i = 0; i < 40 && bus.req; i++) begin
      cycles++;
      tick();
    end
    check("to_req_cycles", cycles, 32'd16);
    check("to_done", {30'd0, lsu_done, lsu_timeout}, 32'b11);
    release_req();

    // Ack on the 16th cycle wins over the timeout
    drive(1'b0, 3'b010, 32'h100, 32'h0);
    tick();
    repeat (15) tick();
    check("ack16_req", {31'd0, bus.req}, 32'd1);
    ack_now(32'h12345678);
    check("ack16_done", {30'd0, lsu_done, lsu_timeout}, 32'b10);
    check("ack16_rdata", lsu_rdata, 32'h12345678);
    release_req();

    // Reset asserted in the second BUSY cycle
    drive(1'b0, 3'b010, 32'h104, 32'h0);
    tick();
    tick();
    check("rb_req_before", {31'd0, bus.req}, 32'd1);
    rst_n   = 1'b0;
    lsu_req = 1'b0;
    #1;
    check("rb_req_async", {31'd0, bus.req}, 32'd0);
    check("rb_sel_async", {28'd0, bus.sel_byte}, 32'd0);
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (lsu_done) dones++;
    end
    check("rb_no_done", dones, 32'd0);

    // Normal access after reset
    drive(1'b1, 3'b001, 32'h106, 32'h0000BEEF);
    tick();
    check("post_rst_sel", {28'd0, bus.sel_byte}, 32'hC);
    check("post_rst_wdata", bus.w_data, 32'hBEEFBEEF);
    ack_now(32'h0);
    check("post_rst_done", {31'd0, lsu_done}, 32'd1);
    release_req();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter XLEN, default 32: data and address width.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: maximum number of BUSY cycles to wait for ack before abort.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 lsu_req_i  input  1  execute requests a memory access; held high until lsu_done_o.
REQ-006 lsu_we_i  input  1  1 = store, 0 = load.
REQ-007 lsu_funct3_i  input  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 lsu_addr_i  input  XLEN  byte address.
REQ-009 lsu_wdata_i  input  XLEN  store data, right-aligned.
REQ-010 lsu2dbus_o  output  type_dbus2peri_s  data bus request: req, addr, w_data, sel_byte, w_en.
REQ-011 dbus2lsu_i  input  type_peri2dbus_s  data bus response: r_data, ack.
REQ-012 lsu_rdata_o  output  XLEN  extracted, sign/zero-extended load result.
REQ-013 lsu_done_o  output  1  one-cycle pulse: access complete or aborted.
REQ-014 lsu_stall_o  output  1  pipeline hold.
REQ-015 lsu_misalign_o  output  1  misaligned or illegal access flag, valid with lsu_done_o.
REQ-016 lsu_timeout_o  output  1  bus timeout flag, valid with lsu_done_o.

Function
REQ-017 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-018 In IDLE with lsu_req_i=1, the access is legal when one of these holds: W with addr[1:0]=00; H/HU with addr[0]=0; B/BU. Every other funct3 value is illegal.
REQ-019 On a legal request in IDLE, the unit SHALL latch the op, addr, funct3 and formatted data, and go to BUSY; lsu2dbus_o.req SHALL be registered high from the next cycle.
REQ-020 On an illegal request in IDLE, the unit SHALL go to DONE with lsu_misalign_o=1 and SHALL issue no bus request.
REQ-021 sel_byte: B = 0001 shifted left by addr[1:0]; H = 0011 if addr[1]=0, else 1100; W = 1111. sel_byte SHALL be 1111 for loads.
REQ-022 w_data: byte replicated 4x; half replicated 2x; word unchanged. bus addr = latched addr.
REQ-023 In BUSY, req SHALL stay high until the first cycle with ack=1. On that edge: req->0, r_data captured, state->DONE.
REQ-024 A load result SHALL select the byte at addr[1:0] or the half at addr[1], then extend it: B/H sign-extend, BU/HU zero-extend, W pass through.
REQ-025 The timeout counter SHALL clear on entry to BUSY and increment every BUSY cycle without ack. When it reaches TIMEOUT_CYCLES-1: req->0, lsu_timeout_o=1, state->DONE.
REQ-026 If ack and the timeout limit occur in the same cycle, ack SHALL win.
REQ-027 DONE SHALL last exactly one cycle with lsu_done_o=1, then return to IDLE. rdata and flags SHALL hold until the next accepted request.
REQ-028 lsu_stall_o = lsu_req_i & ~lsu_done_o (combinational).
REQ-029 A legal request accepted at edge N SHALL give req high in cycle N+1. With the memory acking in cycle N+2, lsu_done_o SHALL be high in cycle N+3.
REQ-030 ack received in IDLE or DONE SHALL be ignored.
REQ-031 lsu_req_i in DONE SHALL NOT start a new access; acceptance occurs in the next IDLE cycle.

Reset
REQ-032 While rst_n=0: state=IDLE; req, w_en, lsu_done_o, lsu_misalign_o, lsu_timeout_o=0; sel_byte=0000; addr, w_data, lsu_rdata_o=0; counter=0.
REQ-033 Reset asserted mid-BUSY SHALL drop req immediately (asynchronously) and discard the access; no lsu_done_o SHALL follow.

Structure
REQ-034 The funct3 encodings, the state enum and TIMEOUT_CYCLES default SHALL reside in the shared memory defines package, alongside type_dbus2peri_s and type_peri2dbus_s.
REQ-035 The load extraction/extension logic SHALL be one combinational sub-module, lsu_load_align.

Verification
REQ-036 SW 0xDEADBEEF to 0x100 -> sel_byte=1111, w_data=0xDEADBEEF, w_en=1, done 3 cycles after acceptance.
REQ-037 SB 0x000000A5 to 0x103 -> sel_byte=1000, w_data=0xA5A5A5A5; then LB from 0x103 -> rdata=0xFFFFFFA5; LBU -> 0x000000A5.
REQ-038 LH from 0x102 with r_data=0x80017FFF -> rdata=0xFFFF8001; LHU -> 0x00008001.
REQ-039 LW from 0x101 -> no bus req, done next cycle, lsu_misalign_o=1; funct3=011 -> same.
REQ-040 Load with no ack -> req high for 16 cycles then low, done with lsu_timeout_o=1; ack on the 16th cycle -> lsu_timeout_o=0.
REQ-041 rst_n=0 in the 2nd BUSY cycle -> req=0 at once, state IDLE, no done pulse; next request proceeds normally.
